// File: rtl/pwm_duty_ramp_pkg.sv
// Shared definitions for the PWM duty ramp block.
//  - default channel count and compare width (must match the downstream PWM bank)
//  - global ramp FSM state encoding, also used by the PWM top
//  - prescaler width helper
package pwm_duty_ramp_pkg;

  localparam int unsigned PWM_NUM_CH  = 8;
  localparam int unsigned PWM_CTR_LEN = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STOP  = 2'd1,
    ST_DRAIN = 2'd2
  } ramp_state_e;

  // A divide-by-1 prescaler never counts, but still needs a 1-bit register.
  function automatic int unsigned presc_width(input int unsigned div);
    if (div <= 1) return 1;
    return $clog2(div);
  endfunction

endpackage

// File: rtl/pwm_duty_ramp_ch.sv
// One ramp channel: holds the target duty and slews the live duty toward it.
// Ports:
//   clk, rstn   clock, async active-low reset
//   tick        ramp step strobe (one cycle)
//   wr_en       load wr_duty into the target
//   wr_duty     new target duty
//   force_zero  hold target at 0 (estop); wins over wr_en
//   duty        live compare value
//   busy        registered duty != target
module pwm_duty_ramp_ch
  import pwm_duty_ramp_pkg::*;
#(
  parameter int unsigned CTR_LEN = PWM_CTR_LEN,
  parameter int unsigned STEP    = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               tick,
  input  logic               wr_en,
  input  logic [CTR_LEN-1:0] wr_duty,
  input  logic               force_zero,
  output logic [CTR_LEN-1:0] duty,
  output logic               busy
);

  localparam logic [CTR_LEN-1:0] STEP_V = CTR_LEN'(STEP);

  logic [CTR_LEN-1:0] duty_q, duty_d;
  logic [CTR_LEN-1:0] target_q, target_d;
  logic [CTR_LEN-1:0] gap;
  logic               busy_q;

  // The step always compares against the old target, so a command landing on
  // a tick edge only takes effect from the following tick. Snapping to the
  // target when the gap is within one step keeps the result inside 0..max.
  always_comb begin
    target_d = target_q;
    if (force_zero) begin
      target_d = '0;
    end else if (wr_en) begin
      target_d = wr_duty;
    end

    duty_d = duty_q;
    gap    = '0;
    if (tick) begin
      if (duty_q < target_q) begin
        gap    = target_q - duty_q;
        duty_d = (gap <= STEP_V) ? target_q : duty_q + STEP_V;
      end else if (duty_q > target_q) begin
        gap    = duty_q - target_q;
        duty_d = (gap <= STEP_V) ? target_q : duty_q - STEP_V;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      duty_q   <= '0;
      target_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      duty_q   <= duty_d;
      target_q <= target_d;
      // Compare next-state values so busy drops on the same edge duty arrives.
      busy_q   <= (duty_d != target_d);
    end
  end

  assign duty = duty_q;
  assign busy = busy_q;

endmodule

// File: rtl/pwm_duty_ramp.sv
// PWM duty ramp: per-channel target registers with slewed live duty values
// feeding the PWM compare inputs, plus estop soft-stop sequencing.
//
//  state | meaning
//  RUN   | commands accepted, channels ramp toward their targets
//  STOP  | estop seen: targets held 0, commands refused, stopped once all duty == 0
//  DRAIN | one cycle after estop release before commands are accepted again
//
// Ports:
//   clk, rstn   clock, async active-low reset
//   cmd_valid   command present          cmd_ready  command accepted this edge
//   cmd_ch      target channel           cmd_duty   new target duty
//   estop       level, ramp all to 0 and refuse commands
//   duty        live compare values, ch i at [i*CTR_LEN +: CTR_LEN]
//   busy        per-channel duty != target
//   cmd_err     1-cycle pulse after an accepted command to a missing channel
//   stopped     STOP state with every channel at 0
module pwm_duty_ramp
  import pwm_duty_ramp_pkg::*;
#(
  parameter int unsigned NUM_CH   = PWM_NUM_CH,
  parameter int unsigned CTR_LEN  = PWM_CTR_LEN,
  parameter int unsigned TICK_DIV = 16,
  parameter int unsigned STEP     = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [3:0]                cmd_ch,
  input  logic [CTR_LEN-1:0]        cmd_duty,
  input  logic                      estop,
  output logic [NUM_CH*CTR_LEN-1:0] duty,
  output logic [NUM_CH-1:0]         busy,
  output logic                      cmd_err,
  output logic                      stopped
);

  localparam int unsigned    PW         = presc_width(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic          tick;
  ramp_state_e   state_q;
  logic          cmd_ready_q;
  logic          stopped_q;
  logic          cmd_err_q;
  logic          accept;
  logic          ch_ok;
  logic          force_zero;
  logic          all_zero;

  // Free-running prescaler, independent of the FSM state.
  assign tick = (presc_q == PRESC_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  assign accept     = cmd_valid & cmd_ready_q;
  assign ch_ok      = ({1'b0, cmd_ch} < 5'(NUM_CH));
  // estop zeroes targets on the very edge it is seen, even before STOP is entered.
  assign force_zero = estop | (state_q == ST_STOP);
  assign all_zero   = ~|duty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_RUN;
      cmd_ready_q <= 1'b0;
      stopped_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      cmd_err_q <= accept & ~ch_ok;
      unique case (state_q)
        ST_RUN: begin
          stopped_q <= 1'b0;
          if (estop) begin
            state_q     <= ST_STOP;
            cmd_ready_q <= 1'b0;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ST_STOP: begin
          cmd_ready_q <= 1'b0;
          if (!estop && stopped_q) begin
            state_q   <= ST_DRAIN;
            stopped_q <= 1'b0;
          end else begin
            stopped_q <= all_zero;
          end
        end
        ST_DRAIN: begin
          stopped_q <= 1'b0;
          if (estop) begin
            state_q     <= ST_STOP;
            cmd_ready_q <= 1'b0;
          end else begin
            state_q     <= ST_RUN;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_RUN;
          cmd_ready_q <= 1'b0;
          stopped_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cmd_err   = cmd_err_q;
  assign stopped   = stopped_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_en;
    assign wr_en = accept & ch_ok & (cmd_ch == 4'(i));

    pwm_duty_ramp_ch #(
      .CTR_LEN (CTR_LEN),
      .STEP    (STEP)
    ) u_ch (
      .clk        (clk),
      .rstn       (rstn),
      .tick       (tick),
      .wr_en      (wr_en),
      .wr_duty    (cmd_duty),
      .force_zero (force_zero),
      .duty       (duty[i*CTR_LEN +: CTR_LEN]),
      .busy       (busy[i])
    );
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
module tb_pwm_duty_ramp;

  localparam int NCH = 8;
  localparam int CW  = 8;
  localparam int TD  = 4;
  localparam int ST  = 4;

  localparam int M_RUN   = 0;
  localparam int M_STOP  = 1;
  localparam int M_DRAIN = 2;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [3:0]        cmd_ch = '0;
  logic [CW-1:0]     cmd_duty = '0;
  logic              estop = 1'b0;
  logic [NCH*CW-1:0] duty;
  logic [NCH-1:0]    busy;
  logic              cmd_err;
  logic              stopped;

  pwm_duty_ramp #(
    .NUM_CH   (NCH),
    .CTR_LEN  (CW),
    .TICK_DIV (TD),
    .STEP     (ST)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ch    (cmd_ch),
    .cmd_duty  (cmd_duty),
    .estop     (estop),
    .duty      (duty),
    .busy      (busy),
    .cmd_err   (cmd_err),
    .stopped   (stopped)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: integer duties/targets, a mode word and an edge count.
  int m_duty[NCH];
  int m_tgt[NCH];
  int m_mode;
  int m_ready;
  int m_stopped;
  int m_err;
  int edge_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_duty[i] = 0;
      m_tgt[i]  = 0;
    end
    m_mode    = M_RUN;
    m_ready   = 0;
    m_stopped = 0;
    m_err     = 0;
    edge_cnt  = 0;
  endtask

  // Apply one clock edge's worth of behaviour using the inputs held at the edge.
  task automatic model_edge();
    bit tick;
    bit acc;
    bit all0;
    int ch;
    tick = ((edge_cnt % TD) == TD - 1);
    edge_cnt++;
    acc = cmd_valid && (m_ready != 0);
    ch  = int'(cmd_ch);
    all0 = 1'b1;
    for (int i = 0; i < NCH; i++) if (m_duty[i] != 0) all0 = 1'b0;

    if (tick) begin
      for (int i = 0; i < NCH; i++) begin
        if (m_tgt[i] > m_duty[i])
          m_duty[i] = (m_tgt[i] - m_duty[i] <= ST) ? m_tgt[i] : m_duty[i] + ST;
        else if (m_tgt[i] < m_duty[i])
          m_duty[i] = (m_duty[i] - m_tgt[i] <= ST) ? m_tgt[i] : m_duty[i] - ST;
      end
    end

    if (estop || m_mode == M_STOP) begin
      for (int i = 0; i < NCH; i++) m_tgt[i] = 0;
    end else if (acc && ch < NCH) begin
      m_tgt[ch] = int'(cmd_duty);
    end

    m_err = (acc && ch >= NCH) ? 1 : 0;

    case (m_mode)
      M_RUN: begin
        if (estop) begin m_mode = M_STOP; m_ready = 0; end
        else m_ready = 1;
        m_stopped = 0;
      end
      M_STOP: begin
        m_ready = 0;
        if (!estop && m_stopped != 0) begin m_mode = M_DRAIN; m_stopped = 0; end
        else m_stopped = all0 ? 1 : 0;
      end
      default: begin
        m_stopped = 0;
        if (estop) begin m_mode = M_STOP; m_ready = 0; end
        else begin m_mode = M_RUN; m_ready = 1; end
      end
    endcase
  endtask

  task automatic compare_all();
    logic [63:0] exp_bus;
    logic [7:0]  exp_busy;
    exp_bus  = '0;
    exp_busy = '0;
    for (int i = 0; i < NCH; i++) begin
      exp_bus[i*CW +: CW] = CW'(m_duty[i]);
      exp_busy[i]         = (m_duty[i] != m_tgt[i]);
    end
    check("duty_bus", duty, exp_bus);
    check("busy", 64'(busy), 64'(exp_busy));
    check("cmd_ready", 64'(cmd_ready), 64'(m_ready));
    check("cmd_err", 64'(cmd_err), 64'(m_err));
    check("stopped", 64'(stopped), 64'(m_stopped));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rstn) model_edge();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic send(input int ch, input int d);
    cmd_valid = 1'b1;
    cmd_ch    = 4'(ch);
    cmd_duty  = CW'(d);
    cyc();
    cmd_valid = 1'b0;
  endtask

  // Position so the next edge is a ramp tick.
  task automatic align_tick();
    for (int k = 0; k < TD && (edge_cnt % TD) != TD - 1; k++) cyc();
  endtask

  initial begin
    model_reset();
    #1;
    compare_all();
    run(3);
    check("rst_ready", 64'(cmd_ready), 64'd0);
    rstn = 1'b1;
    cyc();
    check("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Ramp up on ch2, other channels stay 0.
    send(2, 5);
    run(12);
    check("ch2_final", 64'(duty[23:16]), 64'd5);
    check("others_zero", 64'(duty & ~(64'hFF << 16)), 64'd0);
    check("ch2_idle", 64'(busy[2]), 64'd0);

    // Overshoot clamp on ch0.
    send(0, 10);
    run(16);
    check("ch0_up_clamp", 64'(duty[7:0]), 64'd10);
    send(0, 1);
    run(16);
    check("ch0_dn_clamp", 64'(duty[7:0]), 64'd1);

    // Command on a tick edge: old target used for that step.
    send(1, 3);
    run(8);
    align_tick();
    send(1, 0);
    check("ch1_same_edge", 64'(duty[15:8]), 64'd3);
    run(TD);
    check("ch1_next_tick", 64'(duty[15:8]), 64'd0);
    send(1, 255);
    run(TD * 64 + 8);
    check("ch1_full_scale", 64'(duty[15:8]), 64'd255);

    // Missing channel.
    send(9, 77);
    check("err_pulse", 64'(cmd_err), 64'd1);
    cyc();
    check("err_clear", 64'(cmd_err), 64'd0);

    // Estop from 200 on every channel.
    for (int i = 0; i < NCH; i++) send(i, 200);
    run(TD * 50 + 8);
    estop = 1'b1;
    cyc();
    check("estop_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1; cmd_ch = 4'd3; cmd_duty = 8'd99;
    run(5);
    cmd_valid = 1'b0;
    run(TD * 64 + 8);
    check("stopped_set", 64'(stopped), 64'd1);
    check("all_zero", duty, 64'd0);
    estop = 1'b0;
    cyc();
    check("drain_ready", 64'(cmd_ready), 64'd0);
    check("drain_stopped", 64'(stopped), 64'd0);
    cyc();
    check("run_ready", 64'(cmd_ready), 64'd1);

    // Estop mid-ramp: direction reverses, then a normal recovery.
    send(4, 100);
    run(40);
    estop = 1'b1;
    run(6);
    estop = 1'b0;
    run(TD * 30 + 10);

    // Randomized traffic with occasional estop toggles.
    for (int k = 0; k < 800; k++) begin
      cmd_valid = ($urandom_range(0, 9) < 7);
      cmd_ch    = 4'($urandom_range(0, 10));
      cmd_duty  = CW'($urandom);
      if ($urandom_range(0, 79) == 0) estop = ~estop;
      cyc();
    end
    cmd_valid = 1'b0;
    estop = 1'b0;
    run(TD * 70);

    // Asynchronous reset mid-ramp.
    send(5, 250);
    run(20);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_async_duty", duty, 64'd0);
    check("rst_async_busy", 64'(busy), 64'd0);
    run(2);
    rstn = 1'b1;
    run(4);
    send(6, 9);
    run(TD * 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
